// File: rtl/qoi_pkg.sv
// Shared types and constants for the QOI encoder peripheral: pixel layout,
// chunk tags, register offsets, FSM encoding and the colour hash.
package qoi_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic [7:0] a;
   } pixel_t;

   typedef enum logic [1:0] {IDLE, HASH, CLASS, EMIT} state_t;

   localparam logic [7:0] QOI_OP_INDEX = 8'h00;
   localparam logic [7:0] QOI_OP_DIFF  = 8'h40;
   localparam logic [7:0] QOI_OP_LUMA  = 8'h80;
   localparam logic [7:0] QOI_OP_RUN   = 8'hC0;
   localparam logic [7:0] QOI_OP_RGB   = 8'hFE;
   localparam logic [7:0] QOI_OP_RGBA  = 8'hFF;

   localparam logic [2:0] REG_PIX_R  = 3'd0;
   localparam logic [2:0] REG_PIX_G  = 3'd1;
   localparam logic [2:0] REG_PIX_B  = 3'd2;
   localparam logic [2:0] REG_PIX_A  = 3'd3;
   localparam logic [2:0] REG_CTRL   = 3'd4;
   localparam logic [2:0] REG_STATUS = 3'd4;
   localparam logic [2:0] REG_OUT    = 3'd5;
   localparam logic [2:0] REG_COUNT  = 3'd6;

   localparam logic [5:0] RUN_MAX   = 6'd62;
   localparam pixel_t     PREV_INIT = 32'h0000_00FF;

   function automatic logic [5:0] qoi_hash(input pixel_t p);
      logic [10:0] s;
      s = 11'(p.r) * 11'd3 + 11'(p.g) * 11'd5 + 11'(p.b) * 11'd7 + 11'(p.a) * 11'd11;
      return s[5:0];
   endfunction

endpackage

// File: rtl/qoi_enc_periph_if.sv
// CPU-side register bus of the QOI encoder: chip select, offset, strobe,
// write data, registered read data and busy.
interface qoi_enc_periph_if;
   logic       cs;
   logic [2:0] addr;
   logic       we;
   logic [7:0] di;
   logic [7:0] dout;
   logic       busy;

   modport master (output cs, addr, we, di, input dout, busy);
   modport slave  (input cs, addr, we, di, output dout, busy);
endinterface

// File: rtl/qoi_byte_fifo.sv
// 16x8 synchronous FIFO with occupancy count; clr empties it in one cycle.
module qoi_byte_fifo (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       push,
   input  logic [7:0] wdata,
   input  logic       pop,
   output logic [7:0] rdata,
   output logic       full,
   output logic       empty,
   output logic [4:0] count
);

   logic [7:0] mem [16];
   logic [3:0] wr_ptr, rd_ptr;
   logic       do_push, do_pop;

   assign full    = (count == 5'd16);
   assign empty   = (count == 5'd0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 4'd1;
         if (do_pop)  rd_ptr <= rd_ptr + 4'd1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 5'd1;
            2'b01:   count <= count - 5'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/qoi_enc_periph.sv
// QOI encoding accelerator: register window in front of the hash/index/run
// classifier; chunk bytes are queued in a 16-byte FIFO drained through OUT.
module qoi_enc_periph
   import qoi_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   qoi_enc_periph_if.slave bus
);

   state_t          state, state_n;
   logic            wr, rd, idle;
   logic            commit_req, ctrl_req, commit, start, flush_go, cmd_busy;
   logic [7:0]      lat_r, lat_g, lat_b;
   pixel_t          pix_in, cur, prev, idx_q;
   logic [5:0]      cur_hash, run, cls_run;
   logic [31:0]     index_mem [64];
   logic [63:0]     index_vld;
   logic            overflow, idx_we;
   logic [7:0]      dout_q, rd_val, run_byte;
   logic [5:0][7:0] ebuf, cls_buf;
   logic [4:0][7:0] op_buf;
   logic [2:0]      elen, eptr, op_len, cls_len;
   logic [7:0]      dr, dg, db, dr_dg, db_dg;
   logic            diff_ok, luma_ok;
   logic            push, pop, fifo_full, fifo_empty;
   logic [7:0]      fifo_rdata;
   logic [4:0]      fifo_count;

   assign wr         = bus.cs & bus.we;
   assign rd         = bus.cs & ~bus.we;
   assign idle       = (state == IDLE);
   assign commit_req = wr && (bus.addr == REG_PIX_A);
   assign ctrl_req   = wr && (bus.addr == REG_CTRL) && (bus.di[1:0] != 2'b00);
   assign commit     = commit_req & idle;
   assign start      = ctrl_req & bus.di[0] & idle;
   // start wins over flush in the same write: a flush right after start has run=0
   assign flush_go   = ctrl_req & ~bus.di[0] & idle & (run != '0);
   assign cmd_busy   = (commit_req | ctrl_req) & ~idle;
   assign pix_in     = {lat_r, lat_g, lat_b, bus.di};
   assign run_byte   = QOI_OP_RUN | {2'b00, run - 6'd1};

   assign push = (state == EMIT) & ~fifo_full;
   assign pop  = rd && (bus.addr == REG_OUT) && ~fifo_empty;

   assign bus.dout = dout_q;
   assign bus.busy = ~idle;

   qoi_byte_fifo u_fifo (
      .clk   (clk),
      .reset (reset),
      .clr   (start),
      .push  (push),
      .wdata (ebuf[eptr]),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // 8-bit wrapping deltas; range checks are done by biasing into unsigned space
   assign dr      = cur.r - prev.r;
   assign dg      = cur.g - prev.g;
   assign db      = cur.b - prev.b;
   assign dr_dg   = dr - dg;
   assign db_dg   = db - dg;
   assign diff_ok = ((dr + 8'd2) < 8'd4) && ((dg + 8'd2) < 8'd4) && ((db + 8'd2) < 8'd4);
   assign luma_ok = ((dg + 8'd32) < 8'd64) && ((dr_dg + 8'd8) < 8'd16) && ((db_dg + 8'd8) < 8'd16);

   always_comb begin
      op_buf  = '0;
      op_len  = '0;
      idx_we  = 1'b0;
      cls_buf = '0;
      cls_len = '0;
      cls_run = '0;
      if (cur == prev) begin
         if (run == RUN_MAX - 6'd1) begin
            cls_buf[0] = QOI_OP_RUN | {2'b00, RUN_MAX - 6'd1};
            cls_len    = 3'd1;
         end else begin
            cls_run = run + 6'd1;
         end
      end else begin
         if (idx_q == cur) begin
            op_buf[0] = QOI_OP_INDEX | {2'b00, cur_hash};
            op_len    = 3'd1;
         end else begin
            idx_we = 1'b1;
            if (cur.a != prev.a) begin
               op_buf = {cur.a, cur.b, cur.g, cur.r, QOI_OP_RGBA};
               op_len = 3'd5;
            end else if (diff_ok) begin
               op_buf[0] = QOI_OP_DIFF | {2'b00, 2'(dr + 8'd2), 2'(dg + 8'd2), 2'(db + 8'd2)};
               op_len    = 3'd1;
            end else if (luma_ok) begin
               op_buf[0] = QOI_OP_LUMA | {2'b00, 6'(dg + 8'd32)};
               op_buf[1] = {4'(dr_dg + 8'd8), 4'(db_dg + 8'd8)};
               op_len    = 3'd2;
            end else begin
               op_buf = {8'h00, cur.b, cur.g, cur.r, QOI_OP_RGB};
               op_len = 3'd4;
            end
         end
         if (run != '0) begin
            cls_buf = {op_buf, run_byte};
            cls_len = op_len + 3'd1;
         end else begin
            cls_buf = {8'h00, op_buf};
            cls_len = op_len;
         end
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (commit) state_n = HASH;
                  else if (flush_go) state_n = EMIT;
         HASH:    state_n = CLASS;
         CLASS:   state_n = (cls_len == '0) ? IDLE : EMIT;
         EMIT:    if (push && (eptr == elen - 3'd1)) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      rd_val = '0;
      case (bus.addr)
         REG_STATUS: rd_val = {overflow, 4'b0000, fifo_full, fifo_empty, ~idle};
         REG_OUT:    rd_val = fifo_empty ? 8'h00 : fifo_rdata;
         REG_COUNT:  rd_val = {3'b000, fifo_count};
         default:    rd_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         lat_r     <= '0;
         lat_g     <= '0;
         lat_b     <= '0;
         cur       <= '0;
         cur_hash  <= '0;
         prev      <= PREV_INIT;
         run       <= '0;
         idx_q     <= '0;
         index_vld <= '0;
         elen      <= '0;
         eptr      <= '0;
         overflow  <= 1'b0;
         dout_q    <= '0;
      end else begin
         if (wr && bus.addr == REG_PIX_R) lat_r <= bus.di;
         if (wr && bus.addr == REG_PIX_G) lat_g <= bus.di;
         if (wr && bus.addr == REG_PIX_B) lat_b <= bus.di;
         if (cmd_busy) overflow <= 1'b1;
         if (start) begin
            index_vld <= '0;
            prev      <= PREV_INIT;
            run       <= '0;
            overflow  <= 1'b0;
         end
         if (commit) begin
            cur      <= pix_in;
            cur_hash <= qoi_hash(pix_in);
         end
         if (state == HASH) idx_q <= index_vld[cur_hash] ? index_mem[cur_hash] : '0;
         if (state == CLASS) begin
            run  <= cls_run;
            prev <= cur;
            elen <= cls_len;
            eptr <= '0;
            if (idx_we) index_vld[cur_hash] <= 1'b1;
         end
         if (flush_go) begin
            run  <= '0;
            elen <= 3'd1;
            eptr <= '0;
         end
         if (push) eptr <= eptr + 3'd1;
         if (rd) dout_q <= rd_val;
      end
   end

   // Index contents are qualified by index_vld, so start clears all 64 entries at once
   always_ff @(posedge clk) begin
      if (state == CLASS && idx_we) index_mem[cur_hash] <= cur;
      if (state == CLASS) ebuf <= cls_buf;
      else if (flush_go) ebuf <= {40'h0, run_byte};
   end

endmodule

// File: tb/tb_qoi_enc_periph.sv
// Directed bench for qoi_enc_periph: expected chunk bytes are queued as pixels
// are committed and compared as the FIFO is drained through OUT.
module tb_qoi_enc_periph;

   localparam logic [2:0] A_R = 3'd0, A_G = 3'd1, A_B = 3'd2, A_A = 3'd3;
   localparam logic [2:0] A_CTRL = 3'd4, A_OUT = 3'd5, A_COUNT = 3'd6, A_RSV = 3'd7;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int unsigned n_checks = 0;
   int unsigned n_fail = 0;
   logic [7:0] exp_q [$];
   logic [7:0] v;

   always #5 clk = ~clk;

   qoi_enc_periph_if bus_if ();

   qoi_enc_periph dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] req);
      n_checks++;
      assert (obs === req) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, req);
      end
   endtask

   task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.addr = a; bus_if.di = d;
      @(negedge clk);
      bus_if.cs = 1'b0; bus_if.we = 1'b0;
   endtask

   task automatic bus_rd(input logic [2:0] a, output logic [7:0] d);
      @(negedge clk);
      bus_if.cs = 1'b1; bus_if.we = 1'b0; bus_if.addr = a;
      @(negedge clk);
      bus_if.cs = 1'b0;
      d = bus_if.dout;
   endtask

   task automatic commit(input logic [7:0] r, g, b, a);
      bus_wr(A_R, r); bus_wr(A_G, g); bus_wr(A_B, b); bus_wr(A_A, a);
   endtask

   task automatic wait_idle(input string tag);
      int unsigned n = 0;
      while (bus_if.busy !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      assert (n < 200) else begin
         n_fail++;
         $error("FAIL %s timeout: busy still %b after %0d cycles, expected 0", tag, bus_if.busy, n);
      end
   endtask

   // Called right after a commit/flush write: busy must hold for n sampled cycles, then drop
   task automatic busy_seq(input string tag, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         if (i != 0) @(negedge clk);
         check(tag, {7'd0, bus_if.busy}, 8'h01);
      end
      @(negedge clk);
      check(tag, {7'd0, bus_if.busy}, 8'h00);
   endtask

   task automatic drain(input string tag);
      logic [7:0] d;
      wait_idle(tag);
      bus_rd(A_COUNT, d);
      check({tag, "_count"}, d, 8'(exp_q.size()));
      while (exp_q.size() > 0) begin
         bus_rd(A_OUT, d);
         check(tag, d, exp_q.pop_front());
      end
      bus_rd(A_COUNT, d);
      check({tag, "_empty"}, d, 8'h00);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      bus_if.cs = 1'b0; bus_if.we = 1'b0; bus_if.addr = '0; bus_if.di = '0;
      repeat (3) @(negedge clk);
      check("rst_dout", bus_if.dout, 8'h00);
      check("rst_busy", {7'd0, bus_if.busy}, 8'h00);
      reset = 1'b1;
      bus_rd(A_CTRL, v);  check("rst_status", v, 8'h02);
      bus_rd(A_COUNT, v); check("rst_count", v, 8'h00);
      bus_rd(A_OUT, v);   check("empty_out", v, 8'h00);
      bus_rd(A_RSV, v);   check("rsv_read", v, 8'h00);

      // run of three then flush
      bus_wr(A_CTRL, 8'h01);
      commit(8'h00, 8'h00, 8'h00, 8'hFF);
      busy_seq("run_busy", 2);
      commit(8'h00, 8'h00, 8'h00, 8'hFF); wait_idle("run2");
      commit(8'h00, 8'h00, 8'h00, 8'hFF); wait_idle("run3");
      bus_rd(A_COUNT, v); check("run_nobytes", v, 8'h00);
      bus_wr(A_CTRL, 8'h02);
      exp_q = {exp_q, 8'hC2};
      busy_seq("flush_busy", 1);
      drain("run_flush");

      // DIFF, then index hit on the pixel stored by the DIFF
      bus_wr(A_CTRL, 8'h01);
      commit(8'h01, 8'h01, 8'h01, 8'hFF);
      exp_q = {exp_q, 8'h7F};
      busy_seq("diff_busy", 3);
      commit(8'h00, 8'h00, 8'h00, 8'hFF); exp_q = {exp_q, 8'h55}; wait_idle("diff2");
      commit(8'h01, 8'h01, 8'h01, 8'hFF); exp_q = {exp_q, 8'h04}; wait_idle("diff3");
      drain("diff");

      // LUMA
      bus_wr(A_CTRL, 8'h01);
      commit(8'd10, 8'd10, 8'd10, 8'hFF);
      exp_q = {exp_q, 8'hAA, 8'h88};
      busy_seq("luma_busy", 4);
      drain("luma");

      // RGBA
      bus_wr(A_CTRL, 8'h01);
      commit(8'h12, 8'h34, 8'h56, 8'h80);
      exp_q = {exp_q, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h80};
      busy_seq("rgba_busy", 7);
      drain("rgba");

      // RGB, INDEX, and a pending run emitted ahead of an index hit
      bus_wr(A_CTRL, 8'h01);
      commit(8'h64, 8'h00, 8'h00, 8'hFF); exp_q = {exp_q, 8'hFE, 8'h64, 8'h00, 8'h00}; wait_idle("idx_a");
      commit(8'h00, 8'h64, 8'h00, 8'hFF); exp_q = {exp_q, 8'hFE, 8'h00, 8'h64, 8'h00}; wait_idle("idx_b");
      commit(8'h64, 8'h00, 8'h00, 8'hFF); exp_q = {exp_q, 8'h21}; wait_idle("idx_a2");
      commit(8'h64, 8'h00, 8'h00, 8'hFF); wait_idle("idx_run");
      commit(8'h00, 8'h64, 8'h00, 8'hFF); exp_q = {exp_q, 8'hC0, 8'h29}; wait_idle("idx_b2");
      drain("index");

      // run saturation at 62, remainder flushed
      bus_wr(A_CTRL, 8'h01);
      for (int unsigned i = 0; i < 63; i++) begin
         commit(8'h00, 8'h00, 8'h00, 8'hFF);
         if (i == 61) exp_q = {exp_q, 8'hFD};
         wait_idle("sat");
      end
      bus_wr(A_CTRL, 8'h02);
      exp_q = {exp_q, 8'hC0};
      drain("saturate");

      // FIFO full: emit stalls, commands while busy are ignored and flagged
      bus_wr(A_CTRL, 8'h01);
      for (int unsigned p = 0; p < 4; p++) begin
         logic [7:0] base;
         base = 8'(4 * p + 1);
         commit(base, base + 8'd1, base + 8'd2, base + 8'd3);
         exp_q = {exp_q, 8'hFF, base, base + 8'd1, base + 8'd2, base + 8'd3};
         if (p != 3) wait_idle("fill");
      end
      repeat (10) @(negedge clk);
      check("full_busy", {7'd0, bus_if.busy}, 8'h01);
      bus_rd(A_COUNT, v); check("full_count", v, 8'h10);
      bus_rd(A_CTRL, v);  check("full_status", v, 8'h05);
      bus_wr(A_A, 8'h99);
      bus_rd(A_CTRL, v);  check("ovf_status", v, 8'h85);
      bus_wr(A_CTRL, 8'h01);
      bus_rd(A_COUNT, v); check("start_ignored", v, 8'h10);
      while (exp_q.size() > 0) begin
         bus_rd(A_OUT, v);
         check("full_drain", v, exp_q.pop_front());
      end
      wait_idle("full_done");
      bus_rd(A_COUNT, v); check("full_empty", v, 8'h00);
      bus_rd(A_OUT, v);   check("empty_out2", v, 8'h00);
      bus_rd(A_CTRL, v);  check("ovf_sticky", v, 8'h82);
      bus_wr(A_CTRL, 8'h01);
      bus_rd(A_CTRL, v);  check("ovf_cleared", v, 8'h02);

      // reset mid-pixel drops pending bytes and restores prev
      commit(8'h12, 8'h34, 8'h56, 8'h80);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      check("mid_rst_busy", {7'd0, bus_if.busy}, 8'h00);
      bus_rd(A_COUNT, v); check("mid_rst_count", v, 8'h00);
      commit(8'h00, 8'h00, 8'h00, 8'hFF);
      busy_seq("mid_rst_run", 2);
      bus_wr(A_CTRL, 8'h02);
      exp_q = {exp_q, 8'hC0};
      drain("mid_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
